// File: rtl/service_uart_rx.sv
// -----------------------------------------------------------------------------
// service_uart_rx
//
// Receives 8N1 characters on the q line of the servant SoC, which transmits a
// bit-banged UART. Each received byte is shown on a one-entry valid/ready output.
// Used as an on-board console monitor and as a byte checker in simulation.
//
// Parameters
//   CLKS_PER_BIT  i_clk cycles per UART bit (>= 4)
//   SYNC_STAGES   flops in the i_rx synchronizer (>= 2)
//
// Ports
//   i_clk        clock, the same clock as the service top
//   i_rst        synchronous reset, active high
//   i_rx         serial input, idle high
//   o_data       received byte; the first bit received is the LSB
//   o_valid      o_data holds a byte that has not been consumed
//   i_ready      the consumer accepts o_data while o_valid is high
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_overrun    sticky; a byte was dropped because the holding register was full
//
// Configuration
//   SERVICE_UART_RX_MAJORITY_EN  when defined, each sample point takes the
//   2-of-3 majority of rx_s at counts p-1, p and p+1. When it is not defined,
//   each sample point takes a single sample of rx_s at count p.
// -----------------------------------------------------------------------------
module service_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rx_s;
  logic             rx_bit;
  logic             deliver;

  // The synchronizer resets to ones, which is the idle level of the line.
  // A reset therefore cannot look like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef SERVICE_UART_RX_MAJORITY_EN
  // The stage just before rx_s already holds the value that rx_s takes in the
  // next cycle. So the vote covers counts p-1, p and p+1, and the decision
  // still happens at count p.
  logic rx_d1;
  logic rx_next;

  assign rx_next = sync_q[SYNC_STAGES-2];

  always_ff @(posedge i_clk) begin
    if (i_rst) rx_d1 <= 1'b1;
    else       rx_d1 <= rx_s;
  end

  assign rx_bit = (rx_d1 & rx_s) | (rx_d1 & rx_next) | (rx_s & rx_next);
`else
  assign rx_bit = rx_s;
`endif

  // NOTE: every signal driven in always_comb gets a default value first.
  // Without these defaults, any path that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit is noise. Drop it without a flag.
          state_d = rx_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_bit, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          // Leaving at mid stop bit gives half a bit of margin before the
          // next start edge of a back-to-back frame.
          if (rx_bit) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Hold here while the line stays low, so a break produces no frames.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register. A handshake and a new byte in the same cycle is a
  // replacement, not an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (deliver) begin
      if (valid_q && !i_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its value from before the edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_service_uart_rx.sv
module tb_service_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int compared   = 0;
  int mismatched = 0;

  // Monitor state. Only the monitor process writes these variables.
  int         cyc      = 0;
  int         n_rise   = 0;
  int         n_vcyc   = 0;
  int         n_ferr   = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = '0;
  logic       vprev    = 1'b0;

  // The bench writes this when a start bit begins.
  int start_cyc = 0;

  service_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedges. Outputs are sampled 2 time units after each posedge.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (valid && !vprev) begin
      n_rise++;
      rise_cyc  = cyc;
      rise_data = data;
    end
    if (valid) n_vcyc++;
    if (frame_err) n_ferr++;
    vprev = valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic line_bit(input logic v, input bit glitch);
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      rx = (glitch && c == CPB / 2) ? 1'b0 : v;
    end
  endtask

  task automatic start_bit();
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch3);
    start_bit();
    for (int i = 0; i < 8; i++) line_bit(b[i], glitch3 && i == 3);
    line_bit(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    repeat (4) @(negedge clk);
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", data); end
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", valid); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    idle(10);
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_valid: got %b want 0", valid); end
  endtask

  task automatic test_basic();
    int r0, v0, f0;
    ready = 1'b1;
    r0 = n_rise; v0 = n_vcyc; f0 = n_ferr;
    send_byte(8'h48, 1'b0);
    idle(20);
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL basic_rises: got %0d want 1", n_rise - r0); end
    compared++; if (rise_cyc - start_cyc !== 155) begin mismatched++; $display("FAIL basic_latency: got %0d want 155", rise_cyc - start_cyc); end
    compared++; if (rise_data !== 8'h48) begin mismatched++; $display("FAIL basic_data: got %h want 48", rise_data); end
    compared++; if (n_vcyc - v0 !== 1) begin mismatched++; $display("FAIL basic_valid_cycles: got %0d want 1", n_vcyc - v0); end
    compared++; if (n_ferr - f0 !== 0) begin mismatched++; $display("FAIL basic_ferr: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_overrun();
    int r0;
    @(negedge clk);
    ready = 1'b0;
    r0 = n_rise;
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    idle(20);
    compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL ovr_valid: got %b want 1", valid); end
    compared++; if (data !== 8'h55) begin mismatched++; $display("FAIL ovr_data: got %h want 55", data); end
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL ovr_rises: got %0d want 1", n_rise - r0); end
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #2;
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL ovr_handshake_clear: got %b want 0", valid); end
    idle(5);
  endtask

  task automatic test_false_start();
    int r0, f0;
    r0 = n_rise; f0 = n_ferr;
    repeat (4) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(3 * CPB);
    compared++; if (n_rise - r0 !== 0) begin mismatched++; $display("FAIL fs_rises: got %0d want 0", n_rise - r0); end
    compared++; if (n_ferr - f0 !== 0) begin mismatched++; $display("FAIL fs_ferr: got %0d want 0", n_ferr - f0); end
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL fs_valid: got %b want 0", valid); end
    // A following frame must decode cleanly, which shows the receiver is back in IDLE.
    send_byte(8'h5A, 1'b0);
    idle(10);
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL fs_next_rises: got %0d want 1", n_rise - r0); end
    compared++; if (rise_data !== 8'h5A) begin mismatched++; $display("FAIL fs_next_data: got %h want 5A", rise_data); end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    logic [7:0] b;
    r0 = n_rise; f0 = n_ferr;
    b = 8'h3C;
    start_bit();
    for (int i = 0; i < 8; i++) line_bit(b[i], 1'b0);
    repeat (3) line_bit(1'b0, 1'b0);
    idle(2 * CPB);
    compared++; if (n_ferr - f0 !== 1) begin mismatched++; $display("FAIL fe_pulses: got %0d want 1", n_ferr - f0); end
    compared++; if (n_rise - r0 !== 0) begin mismatched++; $display("FAIL fe_rises: got %0d want 0", n_rise - r0); end
    send_byte(8'h0D, 1'b0);
    idle(10);
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL fe_next_rises: got %0d want 1", n_rise - r0); end
    compared++; if (rise_data !== 8'h0D) begin mismatched++; $display("FAIL fe_next_data: got %h want 0D", rise_data); end
  endtask

  task automatic test_reset_mid_frame();
    int r0;
    logic [7:0] b;
    r0 = n_rise;
    b = 8'h7E;
    start_bit();
    for (int i = 0; i < 4; i++) line_bit(b[i], 1'b0);
    repeat (CPB / 2) begin
      @(negedge clk);
      rx = b[4];
    end
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL mid_rst_data: got %h want 00", data); end
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL mid_rst_ferr: got %b want 0", frame_err); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    idle(2 * CPB);
    send_byte(8'h31, 1'b0);
    idle(10);
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL mid_rst_rises: got %0d want 1", n_rise - r0); end
    compared++; if (rise_data !== 8'h31) begin mismatched++; $display("FAIL mid_rst_next_data: got %h want 31", rise_data); end
  endtask

  task automatic test_glitch();
    int r0;
    logic [7:0] exp;
`ifdef SERVICE_UART_RX_MAJORITY_EN
    exp = 8'hFF;
`else
    exp = 8'hF7;
`endif
    r0 = n_rise;
    send_byte(8'hFF, 1'b1);
    idle(10);
    compared++; if (n_rise - r0 !== 1) begin mismatched++; $display("FAIL glitch_rises: got %0d want 1", n_rise - r0); end
    compared++; if (rise_data !== exp) begin mismatched++; $display("FAIL glitch_data: got %h want %h", rise_data, exp); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
